bench_resp_sisr: RTL and testbench
==================================

# bench_resp_sisr

Downstream response compactor for the benchmark sequential circuits: it consumes the circuit-under-test's output bit(s) over a programmable test window and folds them into a serial/multiple-input signature register. At the end of the window it compares the result against a golden signature. This gives a one-bit pass/fail for trojan-detection runs without logging every response cycle. It sits directly after the benchmark `out` port and before the test controller.

## Interface
- `IN_W`, 1: width of the response input (benchmark `out` width)
- `SIG_W`, 16: signature width; must be ≥ `IN_W` and ≥ 2
- `POLY`, 16'h1021: feedback polynomial taps, `SIG_W` bits
- `SEED`, 16'hFFFF: signature value loaded at window start
- `WIN_W`, 16: width of the window length and the sample counter
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to open a window; sampled only in IDLE
- `win_len`  in  `WIN_W`  number of valid samples to compact; captured on accepted `start`
- `resp_in`  in  `IN_W`  benchmark response
- `resp_valid`  in  1  `resp_in` is a sample to compact this cycle
- `golden`  in  `SIG_W`  expected signature; sampled in the DONE cycle
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse when the window closes
- `signature`  out  `SIG_W`  current or final signature; holds until the next accepted `start`
- `match`  out  1  registered `signature == golden`, updated in the DONE cycle, held until the next accepted `start`
- `toggle_cnt`  out  `WIN_W`  only with `BENCH_RESP_TOGGLE_EN`; see Configuration

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- Reset values: `busy`=0, `done`=0, `signature`=`SEED`, `match`=0, sample counter=0, latched length=0.
- IDLE + `start`:
  - `win_len` != 0: latch `win_len`, load `signature`←`SEED`, clear counter, clear `match`, go to RUN.
  - `win_len` == 0: load `SEED`, go straight to DONE.
- RUN, each cycle with `resp_valid`=1:
  - `sig_next = (signature << 1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zero_ext(resp_in)`; the shift is truncated to `SIG_W`.
  - Increment the counter.
  - If counter == latched length − 1, go to DONE.
- RUN, `resp_valid`=0: signature and counter hold; there is no timeout.
- DONE: `done`=1 for exactly this cycle, and `match` is registered from `signature == golden`. Next state is IDLE.
- `start` in RUN or DONE is ignored and not queued.
- `win_len` changes after acceptance have no effect.
- Counter compare is an equality test, so there is no wrap-around for `win_len` up to 2^`WIN_W`−1.
- Reset asserted mid-window aborts immediately to the reset values. No `done` is issued.

## Timing
- Accepted `start` at edge N gives `busy`=1 from cycle N+1.
- Last valid sample accepted at edge M gives `done`=1 and the final `signature` during cycle M+1.
- `match` is valid from edge M+2 and stays stable thereafter.
- `busy` falls in the same cycle `done` falls.
- Zero-length window: `done` occurs one cycle after `start`.
- Earliest back-to-back restart: `start` may be accepted in the cycle after DONE.

## Configuration
- `BENCH_RESP_TOGGLE_EN` defined:
  - Adds output `toggle_cnt`, which counts valid samples where `resp_in[0]` differs from the previous valid sample.
  - The previous-sample register clears to 0 on accepted `start`.
  - `toggle_cnt` clears on accepted `start`, saturates at all-ones, and holds after DONE.
  - It serves as the switching-activity metric for trojan activation.
- Undefined: the port and its registers are absent; all other behaviour is identical.

## Structure
- Shared package `bench_resp_pkg` holds:
  - FSM state enum `resp_state_t` (IDLE, RUN, DONE)
  - default `POLY`/`SEED` constants
  - a `sisr_step` function implementing `sig_next`
- One sub-module, `sisr_core`: a signature register with load/enable and the polynomial step. The FSM, counter and compare stay in the top level.

## Test plan
All scenarios use `SIG_W`=16, `POLY`=16'h1021, `SEED`=16'hFFFF.

- Reset mid-RUN after 3 samples → outputs return to reset values, no `done`; a subsequent window runs normally.
- `win_len`=1, `resp_in`=0, valid → `done` one cycle later, `signature`=16'hEFDF; with `golden`=16'hEFDF, `match`=1.
- `win_len`=1, `resp_in`=1 → `signature`=16'hEFDE, `match`=0 against `golden`=16'hEFDF.
- `win_len`=2, zeros, with a 5-cycle `resp_valid`=0 gap between samples → `signature`=16'hCF9F, and `done` occurs exactly one cycle after the second valid sample.
- `win_len`=0 → `done` in cycle N+1, `signature`=16'hFFFF; extra `start` pulses during RUN are ignored.
- With `BENCH_RESP_TOGGLE_EN`, `win_len`=4, `resp_in` = 1,0,0,1 → `toggle_cnt`=3.

Source files
------------

// File: rtl/bench_resp_pkg.sv
// ---------------------------------------------------------------------------
// bench_resp_pkg
// Shared definitions for the benchmark response compactor:
//   - resp_state_t : window FSM states (IDLE, RUN, DONE)
//   - DEF_POLY / DEF_SEED : default feedback taps and start signature
//   - sisr_step    : one signature-register step, computed on a wide
//                    container so any SIG_W up to SISR_MAX_W-1 can share it
// ---------------------------------------------------------------------------
package bench_resp_pkg;

    localparam int          SISR_MAX_W = 64;
    localparam logic [15:0] DEF_POLY   = 16'h1021;
    localparam logic [15:0] DEF_SEED   = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } resp_state_t;

    // Shift left (truncated to width), fold in the taps when the outgoing
    // MSB is set, then XOR in the zero-extended response sample.
    function automatic logic [SISR_MAX_W-1:0] sisr_step(
        input logic [SISR_MAX_W-1:0] sig,
        input logic [SISR_MAX_W-1:0] poly,
        input logic [SISR_MAX_W-1:0] din,
        input int unsigned           width
    );
        logic [SISR_MAX_W-1:0] mask;
        logic [SISR_MAX_W-1:0] nxt;
        mask = (64'd1 << width) - 64'd1;
        nxt  = (sig << 1) & mask;
        if (sig[width-1] == 1'b1) begin
            nxt = nxt ^ poly;
        end else begin
            nxt = nxt;
        end
        nxt = nxt ^ din;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/bench_resp_sisr_core.sv
// ---------------------------------------------------------------------------
// sisr_core
// Signature register with synchronous load and step enable.
// Ports:
//   clk, reset (async, active-low)
//   load    : load SEED this cycle (takes priority over en)
//   en      : advance one polynomial step folding in din
//   din     : response sample (IN_W bits, zero-extended into the step)
//   sig     : current signature (registered)
// SIG_W must be in [2, 63] and >= IN_W.
// ---------------------------------------------------------------------------
module sisr_core
    import bench_resp_pkg::*;
#(
    parameter int               IN_W  = 1,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [IN_W-1:0]  din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0]      sig_q;
    logic [SIG_W-1:0]      sig_d;
    logic [SISR_MAX_W-1:0] sig_w;
    logic [SISR_MAX_W-1:0] poly_w;
    logic [SISR_MAX_W-1:0] din_w;
    logic [SISR_MAX_W-1:0] step_w;
    logic                  unused_step_hi;

    // Widen operands into the shared step function's container.
    always_comb begin
        sig_w              = '0;
        poly_w             = '0;
        din_w              = '0;
        sig_w[SIG_W-1:0]   = sig_q;
        poly_w[SIG_W-1:0]  = POLY;
        din_w[IN_W-1:0]    = din;
        step_w             = sisr_step(sig_w, poly_w, din_w, SIG_W);
    end

    // Upper container bits are masked to zero by the step function.
    assign unused_step_hi = ^step_w[SISR_MAX_W-1:SIG_W];

    // Next-signature select: load beats step, otherwise hold.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = step_w[SIG_W-1:0];
        end else begin
            sig_d = sig_q;
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bench_resp_sisr.sv
// ---------------------------------------------------------------------------
// bench_resp_sisr
// Response compactor: folds benchmark responses into a signature over a
// programmable window and compares against a golden value at window end.
// Ports:
//   clk, reset (async, active-low)
//   start      : open a window (only honoured in IDLE)
//   win_len    : number of valid samples, captured on accepted start
//   resp_in    : benchmark response, resp_valid qualifies it
//   golden     : expected signature, sampled in the DONE cycle
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse in the DONE cycle
//   signature  : current/final signature, held until next accepted start
//   match      : signature == golden, registered at end of DONE
//   toggle_cnt : (only with BENCH_RESP_TOGGLE_EN) count of valid samples
//                whose resp_in[0] differs from the previous valid sample
// Optional feature macro: BENCH_RESP_TOGGLE_EN
// ---------------------------------------------------------------------------
module bench_resp_sisr
    import bench_resp_pkg::*;
#(
    parameter int               IN_W  = 1,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED),
    parameter int               WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic [IN_W-1:0]  resp_in,
    input  logic             resp_valid,
    input  logic [SIG_W-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             match
`ifdef BENCH_RESP_TOGGLE_EN
    ,
    output logic [WIN_W-1:0] toggle_cnt
`endif
);

    resp_state_t      state_q, state_d;
    logic [WIN_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             match_q, match_d;
    logic             sig_load_s;
    logic             sig_en_s;
    logic [SIG_W-1:0] sig_s;

    sisr_core #(
        .IN_W  (IN_W),
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_sisr_core (
        .clk   (clk),
        .reset (reset),
        .load  (sig_load_s),
        .en    (sig_en_s),
        .din   (resp_in),
        .sig   (sig_s)
    );

    // Window FSM, sample counter and end-of-window compare.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        match_d    = match_q;
        sig_load_s = 1'b0;
        sig_en_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sig_load_s = 1'b1;
                    cnt_d      = '0;
                    match_d    = 1'b0;
                    if (win_len != '0) begin
                        len_d   = win_len;
                        state_d = RUN;
                    end else begin
                        // Empty window closes immediately on the seed.
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (resp_valid) begin
                    sig_en_s = 1'b1;
                    cnt_d    = cnt_q + WIN_W'(1);
                    // Compare the pre-increment count: this is the last sample.
                    if (cnt_q == (len_q - WIN_W'(1))) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                match_d = (sig_s == golden);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign match     = match_q;
    assign signature = sig_s;

`ifdef BENCH_RESP_TOGGLE_EN
    logic             prev_q, prev_d;
    logic [WIN_W-1:0] tog_q, tog_d;

    // Switching-activity counter on resp_in[0] across valid samples.
    always_comb begin
        prev_d = prev_q;
        tog_d  = tog_q;
        if ((state_q == IDLE) && start) begin
            prev_d = 1'b0;
            tog_d  = '0;
        end else if ((state_q == RUN) && resp_valid) begin
            prev_d = resp_in[0];
            if ((resp_in[0] != prev_q) && (tog_q != {WIN_W{1'b1}})) begin
                tog_d = tog_q + WIN_W'(1);
            end else begin
                tog_d = tog_q;
            end
        end else begin
            prev_d = prev_q;
            tog_d  = tog_q;
        end
    end

    // Toggle tracking registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
            tog_q  <= '0;
        end else begin
            prev_q <= prev_d;
            tog_q  <= tog_d;
        end
    end

    assign toggle_cnt = tog_q;
`endif

endmodule

// File: tb/tb_bench_resp_sisr.sv
// ---------------------------------------------------------------------------
// tb_bench_resp_sisr
// Self-checking bench for bench_resp_sisr (SIG_W=16, POLY=16'h1021,
// SEED=16'hFFFF). A window-level reference model tracks remaining samples
// and the expected signature; a compare process checks every cycle, and
// directed windows pin the model with hand-computed signatures.
// ---------------------------------------------------------------------------
module tb_bench_resp_sisr;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] win_len = 16'd0;
    logic [0:0]  resp_in = 1'b0;
    logic        resp_valid = 1'b0;
    logic [15:0] golden = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic        match;
`ifdef BENCH_RESP_TOGGLE_EN
    logic [15:0] toggle_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    bench_resp_sisr #(
        .IN_W  (1),
        .SIG_W (16),
        .POLY  (16'h1021),
        .SEED  (16'hFFFF),
        .WIN_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .win_len    (win_len),
        .resp_in    (resp_in),
        .resp_valid (resp_valid),
        .golden     (golden),
        .busy       (busy),
        .done       (done),
        .signature  (signature),
        .match      (match)
`ifdef BENCH_RESP_TOGGLE_EN
        ,
        .toggle_cnt (toggle_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic [15:0] m_sig   = 16'hFFFF;
    logic        m_match = 1'b0;
    int          m_left  = 0;
    logic        m_prev  = 1'b0;
    int          m_tog   = 0;

    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic d);
        logic [16:0] wide;
        wide = {s, 1'b0};
        if (wide[16]) wide[15:0] = wide[15:0] ^ 16'h1021;
        return wide[15:0] ^ {15'd0, d};
    endfunction

    // Window-level model: advances once per rising edge from the driven inputs.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_sig = 16'hFFFF; m_match = 1'b0;
            m_left = 0; m_prev = 1'b0; m_tog = 0;
        end else if (m_done) begin
            m_match = (m_sig == golden);
            m_done  = 1'b0;
            m_busy  = 1'b0;
        end else if (m_busy) begin
            if (resp_valid) begin
                m_sig = ref_step(m_sig, resp_in[0]);
                if (resp_in[0] != m_prev && m_tog < 65535) m_tog = m_tog + 1;
                m_prev = resp_in[0];
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end
        end else if (start) begin
            m_sig = 16'hFFFF; m_busy = 1'b1; m_match = 1'b0;
            m_prev = 1'b0; m_tog = 0;
            if (win_len == 16'd0) m_done = 1'b1;
            else m_left = int'(win_len);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare on the falling edge.
    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("signature", {16'd0, signature}, {16'd0, m_sig});
        chk("match", {31'd0, match}, {31'd0, m_match});
`ifdef BENCH_RESP_TOGGLE_EN
        chk("toggle_cnt", {16'd0, toggle_cnt}, m_tog[31:0]);
`endif
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sample(input logic v, input logic d);
        tick();
        start = 1'b0; resp_valid = v; resp_in = d;
    endtask

    task automatic open_win(input logic [15:0] len);
        tick();
        start = 1'b1; win_len = len; resp_valid = 1'b0;
    endtask

    // Randomized window; stimulus runs until the model reports idle.
    task automatic rand_window(input logic [15:0] len);
        int cyc;
        open_win(len);
        cyc = 0;
        forever begin
            tick();
            cyc++;
            win_len = 16'($urandom);
            if (!m_busy) begin
                start = 1'b0; resp_valid = 1'b0;
                break;
            end
            if (cyc > 3000) begin
                n_chk++; n_fail++;
                $display("FAIL window_timeout: got busy expected idle after %0d cycles", cyc);
                start = 1'b0; resp_valid = 1'b0;
                break;
            end
            start      = ($urandom_range(0, 7) == 0);
            resp_valid = ($urandom_range(0, 9) < 7);
            resp_in    = 1'($urandom);
            if (m_done) golden = ($urandom_range(0, 1) == 1) ? m_sig : 16'($urandom);
        end
    endtask

    initial begin
        // Reset and reset-state pins.
        repeat (2) tick();
        reset = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sig", {16'd0, signature}, 32'hFFFF);
        chk("rst_match", {31'd0, match}, 32'd0);

        // Reset mid-RUN after 3 samples.
        open_win(16'd8);
        sample(1'b1, 1'b1); sample(1'b1, 1'b0); sample(1'b1, 1'b1);
        tick();
        resp_valid = 1'b0;
        #2 reset = 1'b0;
        tick();
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_sig", {16'd0, signature}, 32'hFFFF);
        reset = 1'b1;
        open_win(16'd2);
        sample(1'b1, 1'b0); sample(1'b1, 1'b0); sample(1'b0, 1'b0);
        chk("after_rst_sig", {16'd0, signature}, 32'hCF9F);
        chk("after_rst_done", {31'd0, done}, 32'd1);
        tick();

        // win_len=1, resp 0, golden matches.
        open_win(16'd1);
        sample(1'b1, 1'b0);
        chk("w1_busy", {31'd0, busy}, 32'd1);
        win_len = 16'h5555;
        sample(1'b0, 1'b0);
        chk("w1_done", {31'd0, done}, 32'd1);
        chk("w1_sig", {16'd0, signature}, 32'hEFDF);
        golden = 16'hEFDF;
        tick();
        chk("w1_match", {31'd0, match}, 32'd1);
        chk("w1_done_fall", {31'd0, done}, 32'd0);

        // win_len=1, resp 1, golden mismatch.
        open_win(16'd1);
        sample(1'b1, 1'b1);
        sample(1'b0, 1'b0);
        chk("w1b_sig", {16'd0, signature}, 32'hEFDE);
        tick();
        chk("w1b_match", {31'd0, match}, 32'd0);

        // win_len=2 with a 5-cycle gap between samples.
        open_win(16'd2);
        sample(1'b1, 1'b0);
        repeat (5) sample(1'b0, 1'b1);
        chk("gap_no_done", {31'd0, done}, 32'd0);
        sample(1'b1, 1'b0);
        sample(1'b0, 1'b0);
        chk("gap_done", {31'd0, done}, 32'd1);
        chk("gap_sig", {16'd0, signature}, 32'hCF9F);
        tick();

        // Zero-length window, then ignored starts during RUN.
        open_win(16'd0);
        sample(1'b0, 1'b0);
        chk("w0_done", {31'd0, done}, 32'd1);
        chk("w0_sig", {16'd0, signature}, 32'hFFFF);
        open_win(16'd3);
        sample(1'b1, 1'b1);
        tick(); start = 1'b1; win_len = 16'd0; resp_valid = 1'b1;
        tick(); start = 1'b1; resp_valid = 1'b0;
        chk("ign_start_busy", {31'd0, busy}, 32'd1);
        sample(1'b1, 1'b0);
        sample(1'b0, 1'b0);
        chk("ign_start_done", {31'd0, done}, 32'd1);
        chk("ign_start_sig", {16'd0, signature}, {16'd0, ref_step(ref_step(ref_step(16'hFFFF, 1'b1), 1'b1), 1'b0)});
        tick();

`ifdef BENCH_RESP_TOGGLE_EN
        open_win(16'd4);
        sample(1'b1, 1'b1); sample(1'b1, 1'b0); sample(1'b1, 1'b0); sample(1'b1, 1'b1);
        sample(1'b0, 1'b0);
        tick();
        chk("toggle_1001", {16'd0, toggle_cnt}, 32'd3);
`endif

        // Randomized windows, including back-to-back restarts.
        for (int w = 0; w < 60; w++) begin
            rand_window((w % 9 == 0) ? 16'd0 : 16'($urandom_range(1, 14)));
        end
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
